// File: rtl/codec_stream_decoder.sv
// Receive-side XOR decoder: strips the live key from incoming words and buffers them in a FIFO.
// Optional macro CODEC_KEY_ROLL_EN rotates the key left by one bit after every accepted word.
module codec_stream_decoder #(
    parameter int unsigned        DATA_W  = 64,
    parameter int unsigned        DEPTH   = 4,
    parameter logic [DATA_W-1:0]  KEY_RST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_wr_i,
    input  logic [DATA_W-1:0]          key_i,
    output logic [DATA_W-1:0]          key_o,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              push, pop, push_en;

    assign in_ready_o  = (level_q != LvlW'(DEPTH));
    assign out_valid_o = (level_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    // Flush swallows any same-edge push, so no write and no key roll.
    assign push_en     = push & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        key_d    = key_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
`ifdef CODEC_KEY_ROLL_EN
            if (push) key_d = {key_q[DATA_W-2:0], key_q[DATA_W-1]};
`endif
        end
        // An explicit key load beats any roll at the same edge.
        if (key_wr_i) key_d = key_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            key_q    <= KEY_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            key_q    <= key_d;
        end
    end

    // Words are stored already decoded with the key in force before this edge.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            mem[wr_ptr_q] <= in_data_i ^ key_q;
        end
    end

    assign out_data_o = out_valid_o ? mem[rd_ptr_q] : '0;
    assign key_o      = key_q;
    assign level_o    = level_q;

endmodule
